// File: rtl/coin_acceptor_pkg.sv
// Shared constants for the coin acceptor front-end and the vending FSM it feeds.
package coin_acceptor_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned LOCKOUT_CYCLES_DEF  = 8;
  localparam int unsigned CNT_W_DEF           = 8;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] IDLE    = 1'b0;
  localparam logic [STATE_W-1:0] LOCKOUT = 1'b1;

  localparam int unsigned COIN_VALUE_5  = 5;
  localparam int unsigned COIN_VALUE_10 = 10;

  typedef struct packed {
    logic coin_5;
    logic coin_10;
    logic reject;
    logic busy;
  } acc_out_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor/enable inputs and pulse outputs between the coin front-end and its neighbours.
interface coin_acceptor_if;
  logic coin_5_raw;
  logic coin_10_raw;
  logic accept_en;
  logic coin_5;
  logic coin_10;
  logic reject;
  logic busy;

  modport master (
    output coin_5_raw, coin_10_raw, accept_en,
    input  coin_5, coin_10, reject, busy
  );

  modport slave (
    input  coin_5_raw, coin_10_raw, accept_en,
    output coin_5, coin_10, reject, busy
  );
endinterface

// File: rtl/coin_acceptor_debounce.sv
// One coin sensor: two-flop synchroniser, symmetric debounce counter, rising-edge detect.
module coin_acceptor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise_c
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Stable flips on the cycle the disagreement run would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise_c = stable & ~stable_d;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front-end: debounced sensors, accept/reject decision and post-event lockout.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input logic            clk,
  input logic            reset,
  coin_acceptor_if.slave bus
);

  logic               rise_5_c;
  logic               rise_10_c;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [CNT_W-1:0]   lock_cnt;
  logic [CNT_W-1:0]   lock_cnt_nxt;
  acc_out_t           out_q;
  acc_out_t           out_nxt;

  coin_acceptor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_5 (
    .clk    (clk),
    .reset  (reset),
    .raw    (bus.coin_5_raw),
    .rise_c (rise_5_c)
  );

  coin_acceptor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_10 (
    .clk    (clk),
    .reset  (reset),
    .raw    (bus.coin_10_raw),
    .rise_c (rise_10_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lock_cnt <= '0;
      out_q    <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      out_q    <= out_nxt;
    end
  end

  // Rises seen while locked out are dropped without restarting the window.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    out_nxt      = '0;
    case (state)
      IDLE: begin
        if (rise_5_c || rise_10_c) begin
          state_nxt    = LOCKOUT;
          lock_cnt_nxt = '0;
          if (rise_5_c && rise_10_c) begin
            out_nxt.reject = 1'b1;
          end else if (bus.accept_en) begin
            out_nxt.coin_5  = rise_5_c;
            out_nxt.coin_10 = rise_10_c;
          end else begin
            out_nxt.reject = 1'b1;
          end
        end
      end
      LOCKOUT: begin
        if (lock_cnt == CNT_W'(LOCKOUT_CYCLES - 1)) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
    out_nxt.busy = (state_nxt == LOCKOUT);
  end

  assign bus.coin_5  = out_q.coin_5;
  assign bus.coin_10 = out_q.coin_10;
  assign bus.reject  = out_q.reject;
  assign bus.busy    = out_q.busy;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random bouncy traffic against an event-level model.
module tb_coin_acceptor;

  localparam int D = 4;
  localparam int L = 8;

  logic clk = 1'b0;
  logic reset;

  coin_acceptor_if bus ();

  coin_acceptor #(
    .DEBOUNCE_CYCLES (D),
    .LOCKOUT_CYCLES  (L),
    .CNT_W           (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
  endtask

  // Model: raw samples per edge; stable flips once the last D synchronised samples all disagree.
  bit q5[$];
  bit q10[$];
  int n;
  bit st5, st10, rp5, rp10;
  bit lock_valid;
  int lock_edge;
  bit e5, e10, erej, ebusy;

  function automatic bit samp(input int ch, input int k);
    if (k < 0) return 1'b0;
    return (ch == 0) ? q5[k] : q10[k];
  endfunction

  function automatic bit will_flip(input int ch, input bit st, input int edge_i);
    for (int j = 0; j < D; j++)
      if (samp(ch, edge_i - 2 - j) == st) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit r5, input bit r10, input bit en, input bit rst);
    bit n5, n10;
    if (rst) begin
      q5.delete(); q10.delete();
      n = 0; st5 = 0; st10 = 0; rp5 = 0; rp10 = 0; lock_valid = 0; lock_edge = 0;
      e5 = 0; e10 = 0; erej = 0; ebusy = 0;
      return;
    end
    q5.push_back(r5);
    q10.push_back(r10);
    e5 = 0; e10 = 0; erej = 0;
    if ((rp5 || rp10) && (!lock_valid || n > lock_edge + L)) begin
      lock_valid = 1;
      lock_edge  = n;
      if (rp5 && rp10) erej = 1;
      else if (en) begin e5 = rp5; e10 = rp10; end
      else erej = 1;
    end
    ebusy = lock_valid && (n - lock_edge < L);
    n5  = will_flip(0, st5, n)  ? ~st5  : st5;
    n10 = will_flip(1, st10, n) ? ~st10 : st10;
    rp5  = !st5 && n5;
    rp10 = !st10 && n10;
    st5  = n5;
    st10 = n10;
    n++;
  endtask

  int cnt5, cnt10, cntrej;

  task automatic step(input bit r5, input bit r10, input bit en, input bit rst);
    @(negedge clk);
    check("coin_5",  int'(bus.coin_5),  int'(e5));
    check("coin_10", int'(bus.coin_10), int'(e10));
    check("reject",  int'(bus.reject),  int'(erej));
    check("busy",    int'(bus.busy),    int'(ebusy));
    cnt5   += int'(bus.coin_5);
    cnt10  += int'(bus.coin_10);
    cntrej += int'(bus.reject);
    bus.coin_5_raw  = r5;
    bus.coin_10_raw = r10;
    bus.accept_en   = en;
    reset           = rst;
    model_edge(r5, r10, en, rst);
    cyc++;
  endtask

  task automatic hold(input int cycles, input bit r5, input bit r10, input bit en);
    for (int i = 0; i < cycles; i++) step(r5, r10, en, 1'b0);
  endtask

  task automatic clr_counts();
    cnt5 = 0; cnt10 = 0; cntrej = 0;
  endtask

  initial begin
    bit lv5, lv10, en_r;
    reset = 1'b1;
    bus.coin_5_raw = 1'b0; bus.coin_10_raw = 1'b0; bus.accept_en = 1'b1;
    model_edge(1'b0, 1'b0, 1'b1, 1'b1);
    clr_counts();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    hold(5, 1'b0, 1'b0, 1'b1);

    clr_counts();
    hold(20, 1'b1, 1'b0, 1'b1);
    hold(20, 1'b0, 1'b0, 1'b1);
    check("s1_coin5_count", cnt5, 1);
    check("s1_other_count", cnt10 + cntrej, 0);

    clr_counts();
    step(1'b0, 1'b1, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    hold(20, 1'b0, 1'b1, 1'b1);
    hold(20, 1'b0, 1'b0, 1'b1);
    check("s2_coin10_count", cnt10, 1);

    clr_counts();
    hold(20, 1'b1, 1'b1, 1'b1);
    hold(20, 1'b0, 1'b0, 1'b1);
    check("s3_reject_count", cntrej, 1);
    check("s3_coin_count", cnt5 + cnt10, 0);

    clr_counts();
    hold(20, 1'b1, 1'b0, 1'b0);
    hold(20, 1'b0, 1'b0, 1'b1);
    check("s4_reject_count", cntrej, 1);
    check("s4_coin5_count", cnt5, 0);

    clr_counts();
    hold(3, 1'b1, 1'b0, 1'b1);
    hold(17, 1'b1, 1'b1, 1'b1);
    hold(20, 1'b0, 1'b0, 1'b1);
    check("s5_dropped_coin10", cnt10, 0);
    hold(20, 1'b0, 1'b1, 1'b1);
    hold(20, 1'b0, 1'b0, 1'b1);
    check("s5_coin5_count", cnt5, 1);
    check("s5_coin10_count", cnt10, 1);

    clr_counts();
    hold(3, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b1, 1'b1);
    hold(20, 1'b1, 1'b0, 1'b1);
    hold(20, 1'b0, 1'b0, 1'b1);
    check("s6_coin5_count", cnt5, 1);

    lv5 = 0; lv10 = 0; en_r = 1;
    for (int i = 0; i < 3000; i++) begin
      bit g5, g10, rst_r;
      if ($urandom_range(0, 99) < 4) lv5 = ~lv5;
      if ($urandom_range(0, 99) < 4) lv10 = ~lv10;
      if ($urandom_range(0, 99) < 3) en_r = ~en_r;
      g5    = lv5  ^ ($urandom_range(0, 99) < 6);
      g10   = lv10 ^ ($urandom_range(0, 99) < 6);
      rst_r = ($urandom_range(0, 999) < 5);
      step(g5, g10, en_r, rst_r);
    end
    hold(30, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
